// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the processor
// load/store path (port 0, fixed priority) and a secondary master (port 1).
// Port 1 is forced through after MAX_WAIT consecutive refused cycles.
// Grants are combinational; read data comes back registered one cycle later
// with a single-cycle valid pulse to the port that was granted.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4  // legal 1..15
) (
  input  logic        clk,
  input  logic        reset_n,
  // port 0: processor load/store
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic [31:0] p0_rdata,
  output logic        p0_rvalid,
  // port 1: DMA / debug
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic [31:0] p1_rdata,
  output logic        p1_rvalid,
  // memory: combinational read, write committed on the rising edge
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0]  wait1_reg, wait1_next;
  logic        win0, win1;
  logic        p0_rvalid_reg, p1_rvalid_reg;
  logic [31:0] p0_rdata_reg, p1_rdata_reg;

  // Winner selection: port 0 by default, port 1 once it has waited its limit.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (p0_req && p1_req) begin
      if (wait1_reg == WAIT_LIMIT) begin
        win1 = 1'b1;
      end else begin
        win0 = 1'b1;
      end
    end else if (p0_req) begin
      win0 = 1'b1;
    end else if (p1_req) begin
      win1 = 1'b1;
    end
  end

  // Grants are suppressed while reset is held so nothing reaches the memory.
  assign p0_gnt = win0 & reset_n;
  assign p1_gnt = win1 & reset_n;

  // Route the granted port onto the memory bus; drive zeros when idle.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = 32'd0;
    mem_wd = 32'd0;
    if (p0_gnt) begin
      mem_we = p0_we;
      mem_a  = p0_addr;
      mem_wd = p0_wdata;
    end else if (p1_gnt) begin
      mem_we = p1_we;
      mem_a  = p1_addr;
      mem_wd = p1_wdata;
    end
  end

  // Starvation counter: counts refused port-1 cycles, saturating at the limit.
  always_comb begin
    wait1_next = wait1_reg;
    if (!p1_req || p1_gnt) begin
      wait1_next = 4'd0;
    end else if (wait1_reg != WAIT_LIMIT) begin
      wait1_next = wait1_reg + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait1_reg <= 4'd0;
    end else begin
      wait1_reg <= wait1_next;
    end
  end

  // Read-valid pulses: high for the single cycle after a granted read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_rvalid_reg <= 1'b0;
      p1_rvalid_reg <= 1'b0;
    end else begin
      p0_rvalid_reg <= p0_gnt & ~p0_we;
      p1_rvalid_reg <= p1_gnt & ~p1_we;
    end
  end

  // Read data capture into the granted port only; the other port holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_rdata_reg <= 32'd0;
      p1_rdata_reg <= 32'd0;
    end else begin
      if (p0_gnt && !p0_we) begin
        p0_rdata_reg <= mem_rd;
      end
      if (p1_gnt && !p1_we) begin
        p1_rdata_reg <= mem_rd;
      end
    end
  end

  assign p0_rvalid = p0_rvalid_reg;
  assign p1_rvalid = p1_rvalid_reg;
  assign p0_rdata  = p0_rdata_reg;
  assign p1_rdata  = p1_rdata_reg;

endmodule
